pll_reset_ctrl: RTL and testbench
=================================

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: width of the PLL reset pulse, in clkin cycles (range 1..2^20-1).
REQ-002 Parameter LOCK_WAIT, default 50000: lock timeout after PLL reset release, in clkin cycles (range 1..2^20-1).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release (range 1..2^20-1).
REQ-004 Parameter MAX_RETRY, default 3: lock timeouts tolerated before fault (range 1..15).
REQ-005 clkin  in  1  free-running 50 MHz reference; sole clock.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 pll_locked  in  1  PLL locked flag, asynchronous to clkin.
REQ-008 force_relock  in  1  single-cycle request to restart the PLL sequence.
REQ-009 pll_rst  out  1  active-high reset driven to the PLL rst input.
REQ-010 sys_rst_n  out  1  active-low reset released to the PLL clock domains.
REQ-011 ready  out  1  high while in RUN.
REQ-012 fault  out  1  high while in FAULT.
REQ-013 retries  out  4  count of lock timeouts since the last clear.
REQ-014 state  out  3  current FSM encoding: RESET=0, WAIT=1, STABLE=2, RUN=3, FAULT=4.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; "lock" in all rules below means the synchronizer output.
REQ-016 A single 20-bit counter SHALL be cleared on every state entry and SHALL increment every cycle otherwise.
REQ-017 All outputs SHALL be registered Moore decodes of state, valid the cycle the state register takes its value.
REQ-018 RESET: pll_rst=1, sys_rst_n=0; exit to WAIT when counter == RST_CYCLES-1, so pll_rst is high for exactly RST_CYCLES cycles.
REQ-019 WAIT: pll_rst=0, sys_rst_n=0.
- lock=1: go to STABLE.
- Else, when counter == LOCK_WAIT-1: increment retries.
- On that timeout, retries+1 == MAX_RETRY: go to FAULT; otherwise go to RESET.
REQ-020 STABLE: pll_rst=0, sys_rst_n=0.
- lock=0: return to WAIT (fresh timeout window, retries unchanged).
- counter == STABLE_CYCLES-1 with lock=1: go to RUN.
REQ-021 RUN: pll_rst=0, sys_rst_n=1, ready=1; retries SHALL be cleared on entry.
REQ-022 RUN with lock=0: go to RESET; sys_rst_n SHALL be low on the first cycle in RESET; retries unchanged.
REQ-023 FAULT: pll_rst=0, sys_rst_n=0, fault=1; SHALL remain in FAULT until force_relock or reset.
REQ-024 force_relock=1 in any state SHALL go to RESET and clear retries.
- It takes priority over every simultaneous event (timeout, lock change, stable completion).
- In RESET it restarts the pulse counter.
REQ-025 retries SHALL saturate at 15 and never wrap.
REQ-026 Lock loss to sys_rst_n low: at most 3 cycles (2 synchronizer cycles plus 1 state-update cycle).
REQ-027 ready, fault and sys_rst_n SHALL be mutually consistent in every cycle: sys_rst_n == ready, and ready & fault == 0.

Reset
REQ-028 With rst_n=0 at a clkin edge: state=RESET, counter=0, retries=0, synchronizer=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0.
REQ-029 rst_n asserted mid-operation (any state) SHALL apply REQ-028 on the next edge, discarding the count in progress.
REQ-030 After rst_n deasserts, the first RESET pulse SHALL last the full RST_CYCLES.

Verification (RST_CYCLES=4, LOCK_WAIT=20, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-031 Nominal: release rst_n, raise pll_locked 10 cycles later -> pll_rst high exactly 4 cycles; sys_rst_n=1 and ready=1 no earlier than 2+8 cycles after pll_locked rises; retries=0.
REQ-032 Timeout to fault: hold pll_locked=0 -> two RESET pulses of 4 cycles, each followed by a 20-cycle WAIT, with retries 1 then 2; then fault=1, state=4, pll_rst=0; holds indefinitely.
REQ-033 Glitch in STABLE: pll_locked high, dropped for 3 cycles after 5 STABLE cycles, then high -> return to WAIT with no retry increment; RUN reached only after 8 fresh consecutive lock cycles.
REQ-034 Lock loss in RUN: drop pll_locked -> sys_rst_n=0 and ready=0 within 3 cycles; pll_rst 4-cycle pulse follows; re-lock returns to RUN.
REQ-035 Priority: in FAULT assert force_relock -> RESET with retries=0; separately, assert force_relock on the exact cycle of a WAIT timeout -> RESET with retries=0, not FAULT.
REQ-036 Reset mid-STABLE: pull rst_n low for 1 cycle at STABLE counter=6 -> all outputs per REQ-028 next cycle; a full 4-cycle pll_rst pulse follows.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
//-----------------------------------------------------------------------------
// pll_reset_ctrl
//
// Sequences the reset of a PLL and of the logic clocked by it. The PLL is held
// in reset for a fixed pulse, then given a bounded window to report lock. Lock
// must then hold for a run of consecutive cycles before the downstream domains
// are released. Repeated lock timeouts end in a sticky FAULT state that only
// force_relock or rst_n can leave.
//
// Ports
//   clkin        in   free-running reference clock, the only clock here
//   rst_n        in   synchronous active-low reset
//   pll_locked   in   PLL lock flag, asynchronous to clkin
//   force_relock in   one-cycle request to restart the whole sequence
//   pll_rst      out  active-high reset to the PLL
//   sys_rst_n    out  active-low reset to the PLL clock domains
//   ready        out  high while in RUN
//   fault        out  high while in FAULT
//   retries      out  lock timeouts since the last clear (saturates at 15)
//   state        out  FSM encoding: RESET=0 WAIT=1 STABLE=2 RUN=3 FAULT=4
//
// Every output is a register loaded on the same edge as the state register,
// so outputs and state always describe the same cycle.
//-----------------------------------------------------------------------------
module pll_reset_ctrl #(
    parameter int unsigned RST_CYCLES    = 32'd16,
    parameter int unsigned LOCK_WAIT     = 32'd50000,
    parameter int unsigned STABLE_CYCLES = 32'd1024,
    parameter int unsigned MAX_RETRY     = 32'd3
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retries,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // Terminal counts: the counter starts at zero on state entry, so a phase
    // of N cycles ends when the counter reads N-1.
    localparam logic [19:0] RST_LAST    = 20'(RST_CYCLES - 32'd1);
    localparam logic [19:0] WAIT_LAST   = 20'(LOCK_WAIT - 32'd1);
    localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 32'd1);
    localparam logic [4:0]  MAX_RETRY_W = 5'(MAX_RETRY);

    state_t      state_r;
    state_t      state_next_s;
    logic [19:0] cnt_r;
    logic [3:0]  retries_r;
    logic [3:0]  retries_next_s;
    logic [4:0]  retries_inc_s;
    logic        entry_s;
    logic        lock_meta_r;
    logic        lock_sync_r;
    logic [3:0]  out_next_s;

    // Retry count one step up, held at 15 instead of wrapping.
    function automatic logic [3:0] retries_sat_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'd15) begin
            r = 4'd15;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // Moore output decode, packed as {pll_rst, sys_rst_n, ready, fault}.
    // sys_rst_n and ready share the RUN decode so they can never disagree.
    function automatic logic [3:0] decode_outputs(input state_t s);
        logic [3:0] v;
        case (s)
            ST_RESET:  v = 4'b1000;
            ST_WAIT:   v = 4'b0000;
            ST_STABLE: v = 4'b0000;
            ST_RUN:    v = 4'b0110;
            ST_FAULT:  v = 4'b0001;
            default:   v = 4'b1000;
        endcase
        return v;
    endfunction

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Widened increment so the fault test cannot be fooled by saturation.
    assign retries_inc_s = {1'b0, retries_r} + 5'd1;

    // Next-state and next-retry logic; force_relock overrides every other event.
    always_comb begin
        state_next_s   = state_r;
        retries_next_s = retries_r;
        if (force_relock) begin
            state_next_s   = ST_RESET;
            retries_next_s = 4'd0;
        end else begin
            case (state_r)
                ST_RESET: begin
                    if (cnt_r == RST_LAST) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_RESET;
                    end
                end
                ST_WAIT: begin
                    if (lock_sync_r) begin
                        state_next_s = ST_STABLE;
                    end else if (cnt_r == WAIT_LAST) begin
                        // Timeout: count it, then either retry or give up.
                        retries_next_s = retries_sat_inc(retries_r);
                        if (retries_inc_s == MAX_RETRY_W) begin
                            state_next_s = ST_FAULT;
                        end else begin
                            state_next_s = ST_RESET;
                        end
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
                ST_STABLE: begin
                    if (!lock_sync_r) begin
                        // Lock dropped: new timeout window, retries untouched.
                        state_next_s = ST_WAIT;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_next_s   = ST_RUN;
                        retries_next_s = 4'd0;
                    end else begin
                        state_next_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_next_s = ST_RESET;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_next_s = ST_FAULT;
                end
                default: begin
                    // Unreachable encodings recover through a full reset pulse.
                    state_next_s = ST_RESET;
                end
            endcase
        end
    end

    // A state entry restarts the counter; force_relock in RESET counts as one.
    always_comb begin
        entry_s    = force_relock | (state_next_s != state_r);
        out_next_s = decode_outputs(state_next_s);
    end

    // State, counter, retry count and registered output decodes.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_r   <= ST_RESET;
            cnt_r     <= 20'd0;
            retries_r <= 4'd0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            retries_r <= retries_next_s;
            if (entry_s) begin
                cnt_r <= 20'd0;
            end else begin
                cnt_r <= cnt_r + 20'd1;
            end
            pll_rst   <= out_next_s[3];
            sys_rst_n <= out_next_s[2];
            ready     <= out_next_s[1];
            fault     <= out_next_s[0];
        end
    end

    assign retries = retries_r;
    assign state   = state_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
//-----------------------------------------------------------------------------
// tb_pll_reset_ctrl
//
// Drives pll_reset_ctrl with directed scenarios and random lock/relock/reset
// traffic. A behavioural model tracks the sequence as "phase plus cycles left
// in the phase" and is compared against every DUT output after every edge.
//-----------------------------------------------------------------------------
module tb_pll_reset_ctrl;

    localparam int RST    = 4;
    localparam int LWAIT  = 20;
    localparam int STABLE = 8;
    localparam int MAXR   = 2;

    // {pad, state, pll_rst, sys_rst_n, ready, fault, retries}
    localparam logic [31:0] RESET_VEC  = {21'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    localparam logic [31:0] FAULT2_VEC = {21'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2};

    logic       clkin;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retries;
    logic [2:0] state;

    int n_cmp;
    int n_err;
    int n_cyc;

    // Model: phase 0..4 = RESET WAIT STABLE RUN FAULT; left = cycles remaining.
    int m_phase;
    int m_left;
    int m_retry;
    bit m_meta;
    bit m_lock;

    // pll_rst pulse monitor
    int run_len;
    int last_pulse;
    int n_pulses;

    pll_reset_ctrl #(
        .RST_CYCLES   (RST),
        .LOCK_WAIT    (LWAIT),
        .STABLE_CYCLES(STABLE),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .fault       (fault),
        .retries     (retries),
        .state       (state)
    );

    initial clkin = 1'b0;
    always #10 clkin = ~clkin;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, n_cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {21'd0, state, pll_rst, sys_rst_n, ready, fault, retries};
    endfunction

    function automatic logic [31:0] model_vec();
        return {21'd0, 3'(m_phase), (m_phase == 0), (m_phase == 3), (m_phase == 3),
                (m_phase == 4), 4'(m_retry)};
    endfunction

    function automatic int phase_len(input int p);
        case (p)
            0:       return RST;
            1:       return LWAIT;
            2:       return STABLE;
            default: return 0;
        endcase
    endfunction

    task automatic enter(input int p);
        m_phase = p;
        m_left  = phase_len(p);
    endtask

    // One clock edge of the intended behaviour.
    task automatic model_step(input bit lk, input bit fr, input bit rn);
        bit lock_now;
        if (!rn) begin
            enter(0);
            m_retry = 0;
            m_meta  = 1'b0;
            m_lock  = 1'b0;
        end else begin
            lock_now = m_lock;
            m_lock   = m_meta;
            m_meta   = lk;
            if (fr) begin
                enter(0);
                m_retry = 0;
            end else begin
                case (m_phase)
                    0: if (m_left == 1) enter(1); else m_left--;
                    1: begin
                        if (lock_now) enter(2);
                        else if (m_left == 1) begin
                            m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
                            if (m_retry == MAXR) enter(4); else enter(0);
                        end else m_left--;
                    end
                    2: begin
                        if (!lock_now) enter(1);
                        else if (m_left == 1) begin
                            enter(3);
                            m_retry = 0;
                        end else m_left--;
                    end
                    3: if (!lock_now) enter(0);
                    default: ;
                endcase
            end
        end
    endtask

    // Apply inputs, clock once, compare everything at the falling edge.
    task automatic cyc(input bit lk, input bit fr, input bit rn);
        rst_n        = rn;
        pll_locked   = lk;
        force_relock = fr;
        @(posedge clkin);
        model_step(lk, fr, rn);
        @(negedge clkin);
        n_cyc++;
        check_eq("cycle", dut_vec(), model_vec());
        if (pll_rst === 1'b1) begin
            if (!rn || fr) run_len = 1;
            else run_len++;
        end else if (run_len > 0) begin
            last_pulse = run_len;
            n_pulses++;
            run_len = 0;
        end
    endtask

    task automatic lock_until_ready(input string tag, output int calls);
        calls = 0;
        while (ready !== 1'b1 && calls < 100) begin
            cyc(1'b1, 1'b0, 1'b1);
            calls++;
        end
        check_eq(tag, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int p0;
        int guard;
        bit saw_wait;
        n_cmp = 0; n_err = 0; n_cyc = 0;
        run_len = 0; last_pulse = 0; n_pulses = 0;
        m_phase = 0; m_left = RST; m_retry = 0; m_meta = 1'b0; m_lock = 1'b0;
        rst_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;

        // Reset state
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check_eq("reset_vec", dut_vec(), RESET_VEC);

        // Nominal: lock rises 10 cycles after release
        repeat (10) cyc(1'b0, 1'b0, 1'b1);
        check_eq("nom_pulse", 32'(last_pulse), 32'd4);
        lat = 0;
        while (sys_rst_n !== 1'b1 && lat < 60) begin
            cyc(1'b1, 1'b0, 1'b1);
            lat++;
        end
        // edge that samples the rise + 1 sync + 1 to STABLE + 8 stable = 11 edges
        check_eq("nom_latency", 32'(lat), 32'd11);
        check_eq("nom_retries", 32'(retries), 32'd0);

        // Lock loss in RUN
        lat = 0;
        while (sys_rst_n !== 1'b0 && lat < 10) begin
            cyc(1'b0, 1'b0, 1'b1);
            lat++;
        end
        check_eq("loss_latency", 32'(lat), 32'd3);
        check_eq("loss_ready", {31'd0, ready}, 32'd0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1);
        lock_until_ready("relock_ready", lat);
        check_eq("loss_pulse", 32'(last_pulse), 32'd4);

        // Timeout to fault
        cyc(1'b0, 1'b0, 1'b0);
        p0 = n_pulses;
        repeat (80) cyc(1'b0, 1'b0, 1'b1);
        check_eq("fault_pulses", 32'(n_pulses - p0), 32'd2);
        check_eq("fault_pulse_len", 32'(last_pulse), 32'd4);
        check_eq("fault_vec", dut_vec(), FAULT2_VEC);

        // force_relock out of FAULT
        cyc(1'b0, 1'b1, 1'b1);
        check_eq("relock_from_fault", dut_vec(), RESET_VEC);

        // force_relock on the exact cycle of the second WAIT timeout
        guard = 0;
        while (!(m_phase == 1 && m_left == 1 && m_retry == 1 && !m_lock) && guard < 200) begin
            cyc(1'b0, 1'b0, 1'b1);
            guard++;
        end
        cyc(1'b0, 1'b1, 1'b1);
        check_eq("relock_at_timeout", dut_vec(), RESET_VEC);

        // Glitch after 5 STABLE cycles
        guard = 0;
        while (!(m_phase == 2 && m_left == STABLE - 5) && guard < 100) begin
            cyc(1'b1, 1'b0, 1'b1);
            guard++;
        end
        saw_wait = 1'b0;
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (state === 3'd1) saw_wait = 1'b1;
        end
        check_eq("glitch_to_wait", {31'd0, saw_wait}, 32'd1);
        lock_until_ready("glitch_ready", lat);
        check_eq("glitch_latency", 32'(lat), 32'd11);
        check_eq("glitch_retries", 32'(retries), 32'd0);

        // rst_n pulse at STABLE counter 6
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        guard = 0;
        while (!(m_phase == 2 && m_left == STABLE - 6) && guard < 100) begin
            cyc(1'b1, 1'b0, 1'b1);
            guard++;
        end
        check_eq("stable6_reached", {29'd0, state}, 32'd2);
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("mid_reset_vec", dut_vec(), RESET_VEC);
        repeat (6) cyc(1'b1, 1'b0, 1'b1);
        check_eq("mid_reset_pulse", 32'(last_pulse), 32'd4);

        // Random traffic
        for (int seg = 0; seg < 150; seg++) begin
            bit lk;
            int len;
            lk  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                cyc(lk, ($urandom_range(0, 39) == 0), !($urandom_range(0, 79) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
